// File: rtl/systolic_result_sink.sv
// systolic_result_sink: consumes the feeder's paired activation/weight stream,
// forms signed lane-wise dot products, accumulates them over a configured beat
// count and writes each finished sum to consecutive unified-buffer addresses
// through a small result FIFO that absorbs write-side stalls.
module systolic_result_sink #(
  parameter int WORD_SIZE      = 32,
  parameter int LANE_BITS      = 8,
  parameter int WORD_ADDR_BITS = 16,
  parameter int ACC_BITS       = 32,
  parameter int CNT_BITS       = 10,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      config_valid,
  input  logic [WORD_ADDR_BITS-1:0] dst_addr,
  input  logic [CNT_BITS-1:0]       acc_len,
  input  logic [CNT_BITS-1:0]       out_total,
  output logic                      ack,
  output logic                      busy,
  output logic                      done,
  output logic                      overflow,
  input  logic                      DI_valid,
  input  logic [WORD_SIZE-1:0]      DI_uni,
  input  logic [WORD_SIZE-1:0]      DI_wei,
  input  logic                      wr_ready,
  output logic                      wr_wen,
  output logic [WORD_ADDR_BITS-1:0] wr_addr,
  output logic [ACC_BITS-1:0]       wr_data
);

  localparam int LANES     = WORD_SIZE / LANE_BITS;
  localparam int PROD_BITS = 2 * LANE_BITS;
  localparam int PTR_BITS  = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } SinkState;

  SinkState r_state;
  SinkState w_stateNext;

  logic [WORD_ADDR_BITS-1:0] r_dstAddr;
  logic [CNT_BITS-1:0]       r_accLen;
  logic [CNT_BITS-1:0]       r_outTotal;
  logic [CNT_BITS-1:0]       r_beatCnt;
  logic [CNT_BITS-1:0]       r_resCnt;
  logic [ACC_BITS-1:0]       r_acc;
  logic                      r_ack;
  logic                      r_done;
  logic                      r_zeroPend;
  logic                      r_overflow;

  logic [WORD_ADDR_BITS-1:0] r_fifoAddr [FIFO_DEPTH];
  logic [ACC_BITS-1:0]       r_fifoData [FIFO_DEPTH];
  logic [PTR_BITS-1:0]       r_wrPtr;
  logic [PTR_BITS-1:0]       r_rdPtr;
  logic [PTR_BITS:0]         r_count;

  logic                      w_accept;
  logic                      w_zeroJob;
  logic                      w_finish;
  logic                      w_lastBeat;
  logic                      w_lastResult;
  logic                      w_push;
  logic                      w_pushOk;
  logic                      w_pop;
  logic                      w_fifoEmpty;
  logic                      w_fifoFull;
  logic [ACC_BITS-1:0]       w_laneProd [LANES];
  logic [ACC_BITS-1:0]       w_beatSum;
  logic [ACC_BITS-1:0]       w_accNext;
  logic [WORD_ADDR_BITS-1:0] w_pushAddr;

  // Each lane is multiplied as signed LANE_BITS operands, then sign-extended to the accumulator width.
  for (genvar g = 0; g < LANES; g++) begin : gLane
    logic signed [PROD_BITS-1:0] w_prodRaw;
    assign w_prodRaw = $signed(DI_uni[g*LANE_BITS +: LANE_BITS]) *
                       $signed(DI_wei[g*LANE_BITS +: LANE_BITS]);
    assign w_laneProd[g] = {{(ACC_BITS-PROD_BITS){w_prodRaw[PROD_BITS-1]}}, w_prodRaw};
  end

  // Sum of lane products for the current beat; wraps modulo 2^ACC_BITS.
  always_comb begin
    w_beatSum = '0;
    for (int i = 0; i < LANES; i++) begin
      w_beatSum = w_beatSum + w_laneProd[i];
    end
  end

  assign w_accNext    = (r_beatCnt == '0) ? w_beatSum : r_acc + w_beatSum;
  assign w_lastBeat   = (r_beatCnt == r_accLen - CNT_BITS'(1));
  assign w_lastResult = (r_resCnt == r_outTotal - CNT_BITS'(1));
  assign w_pushAddr   = r_dstAddr + {{(WORD_ADDR_BITS-CNT_BITS){1'b0}}, r_resCnt};

  assign w_fifoEmpty = (r_count == '0);
  assign w_fifoFull  = (r_count == (PTR_BITS+1)'(FIFO_DEPTH));
  assign w_push      = (r_state == RUN) && DI_valid && w_lastBeat;
  assign w_pop       = !w_fifoEmpty && wr_ready;
  assign w_pushOk    = w_push && (!w_fifoFull || w_pop);

  assign wr_wen   = w_pop;
  assign wr_addr  = w_fifoEmpty ? '0 : r_fifoAddr[r_rdPtr];
  assign wr_data  = w_fifoEmpty ? '0 : r_fifoData[r_rdPtr];
  assign ack      = r_ack;
  assign done     = r_done;
  assign overflow = r_overflow;
  assign busy     = (r_state != IDLE);

  // State register for the job sequencer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state logic; DRAIN finishes on the edge that empties the FIFO so done lands right after the last pop.
  always_comb begin
    w_stateNext = r_state;
    w_accept    = 1'b0;
    w_zeroJob   = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      IDLE: begin
        if (config_valid) begin
          if (acc_len == '0 || out_total == '0) begin
            w_zeroJob = 1'b1;
          end else begin
            w_accept    = 1'b1;
            w_stateNext = RUN;
          end
        end
      end
      RUN: begin
        if (DI_valid && w_lastBeat && w_lastResult) begin
          w_stateNext = DRAIN;
        end
      end
      DRAIN: begin
        if (w_fifoEmpty || (r_count == {{PTR_BITS{1'b0}}, 1'b1} && w_pop)) begin
          w_finish    = 1'b1;
          w_stateNext = IDLE;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // Job configuration, beat/result counters, accumulator and handshake pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dstAddr  <= '0;
      r_accLen   <= '0;
      r_outTotal <= '0;
      r_beatCnt  <= '0;
      r_resCnt   <= '0;
      r_acc      <= '0;
      r_ack      <= 1'b0;
      r_done     <= 1'b0;
      r_zeroPend <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_ack      <= w_accept || w_zeroJob;
      r_zeroPend <= w_zeroJob;
      r_done     <= w_finish || r_zeroPend;
      if (w_accept) begin
        r_dstAddr  <= dst_addr;
        r_accLen   <= acc_len;
        r_outTotal <= out_total;
        r_beatCnt  <= '0;
        r_resCnt   <= '0;
        r_acc      <= '0;
        r_overflow <= 1'b0;
      end else if (r_state == RUN && DI_valid) begin
        r_acc <= w_accNext;
        if (w_lastBeat) begin
          r_beatCnt <= '0;
          r_resCnt  <= r_resCnt + CNT_BITS'(1);
        end else begin
          r_beatCnt <= r_beatCnt + CNT_BITS'(1);
        end
        if (w_push && !w_pushOk) begin
          r_overflow <= 1'b1;
        end
      end
    end
  end

  // FIFO pointers and occupancy; a full FIFO still accepts a push when the head pops in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_pushOk) begin
        r_wrPtr <= r_wrPtr + PTR_BITS'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_BITS'(1);
      end
      case ({w_pushOk, w_pop})
        2'b10:   r_count <= r_count + (PTR_BITS+1)'(1);
        2'b01:   r_count <= r_count - (PTR_BITS+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (w_pushOk) begin
      r_fifoAddr[r_wrPtr] <= w_pushAddr;
      r_fifoData[r_wrPtr] <= w_accNext;
    end
  end

endmodule

// File: doc/systolic_result_sink.md
# systolic_result_sink

Consumer at the far end of the systolic feeder's data-out stream. Takes the paired `DI_uni`/`DI_wei` words the feeder emits on `DI_valid` and splits each word into signed lanes. It multiplies the lanes pairwise and accumulates dot products over a configured number of beats. Each finished result goes through a small result FIFO, which writes it back into the unified buffer at consecutive addresses and buffers results while the buffer is not ready.

## Interface
Parameters:
- `WORD_SIZE`, 32: stream word width; must be a multiple of `LANE_BITS`.
- `LANE_BITS`, 8: signed lane width. Lane count is `N = WORD_SIZE/LANE_BITS`.
- `WORD_ADDR_BITS`, 16: unified-buffer address width.
- `ACC_BITS`, 32: accumulator and write-data width.
- `CNT_BITS`, 10: width of the beat and result counters.
- `FIFO_DEPTH`, 4: result FIFO entries; must be a power of two.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `config_valid` in 1: start request; sampled only in IDLE.
- `dst_addr` in `WORD_ADDR_BITS`: address where the first result is written.
- `acc_len` in `CNT_BITS`: number of beats per result.
- `out_total` in `CNT_BITS`: number of results in the job.
- `ack` out 1: one-cycle pulse confirming the config was accepted.
- `busy` out 1: high while in RUN or DRAIN.
- `done` out 1: one-cycle pulse when the job is complete.
- `overflow` out 1: sticky flag; a result was dropped because the FIFO was full.
- `DI_valid` in 1: stream beat valid. The stream has no backpressure.
- `DI_uni` in `WORD_SIZE`: activation word.
- `DI_wei` in `WORD_SIZE`: weight word.
- `wr_ready` in 1: unified buffer can accept a write this cycle.
- `wr_wen` out 1: write strobe, active-high.
- `wr_addr` out `WORD_ADDR_BITS`: write address.
- `wr_data` out `ACC_BITS`: write data.

## Operation
- States: IDLE, RUN, DRAIN.
- **IDLE → RUN** on `config_valid`:
  - latch `dst_addr`, `acc_len`, `out_total`;
  - clear `beat_cnt`, `res_cnt`, the accumulator and `overflow`;
  - pulse `ack`.
- **IDLE, zero-length job:** if `acc_len==0` or `out_total==0`, pulse `ack`, then pulse `done` on the next cycle and stay in IDLE. No writes are issued.
- **Beat product:** `p = Σ sext(uni_lane_i) * sext(wei_lane_i)`, computed on signed `LANE_BITS` operands and sign-extended to `ACC_BITS`.
- **Accumulation:** all additions wrap modulo 2^`ACC_BITS`.
- **RUN, per `DI_valid` beat:**
  - `acc <= (beat_cnt==0) ? p : acc+p`.
  - If `beat_cnt==acc_len-1`: push `{dst+res_cnt, acc+p}` into the FIFO (acc+p is the value after this beat's add, i.e. the completed sum), clear `beat_cnt`, increment `res_cnt`. If this is the last result (`res_cnt==out_total-1`), go to DRAIN.
  - Otherwise increment `beat_cnt`.
- **RUN, `DI_valid` low:** hold all state.
- **DRAIN:** when the FIFO is empty, pulse `done` and return to IDLE.
- **Ignored inputs:**
  - `DI_valid` in IDLE and DRAIN.
  - `config_valid` outside IDLE; `ack` stays 0.
- **Write port:**
  - `wr_wen = !fifo_empty & wr_ready`; `wr_addr`/`wr_data` show the FIFO head.
  - The FIFO pops on every edge where `wr_wen` is high.
  - When the FIFO is empty, `wr_addr`/`wr_data` drive 0.
- **FIFO full:**
  - A push with no pop in the same cycle drops the result and sets `overflow`. `res_cnt` still advances.
  - A push and pop in the same cycle while full is legal and loses nothing.
- **Address arithmetic:** `dst+res_cnt` is truncated to `WORD_ADDR_BITS` and wraps.

## Timing
- **Reset:** `rst` high at an edge forces IDLE and empties the FIFO. All outputs read 0 in the next cycle (`ack`, `busy`, `done`, `overflow`, `wr_wen`, `wr_addr`, `wr_data`). This holds mid-job as well; any in-flight results are discarded.
- **`ack`:** high in the cycle after the `config_valid` edge.
- **`busy`:** high from the cycle after the `config_valid` edge through the cycle before `done`.
- **Result latency:** last beat of a result sampled at edge t → `wr_wen` high in cycle t+1 if `wr_ready` is high and the FIFO was otherwise empty.
- **`done` timing:** high for exactly one cycle, in the cycle after the edge that pops the final FIFO entry.
- **Zero-length job:** `ack` at cycle t+1, `done` at cycle t+2.
- **Back-to-back jobs:** a new `config_valid` is accepted in the cycle `done` is high.

## Test plan
- **Basic job:** `acc_len=3`, `out_total=2`, `dst_addr=0x100`, every beat `DI_uni=0x01020304`, `DI_wei=0x01010101`, `wr_ready=1` → writes 30 to 0x100 and 30 to 0x101, then one `done` pulse, `overflow=0`.
- **Signed lanes:** `acc_len=1`, `out_total=1`, `DI_uni=0x7F0180FF`, `DI_wei=0x7F80FF80` → `wr_data` = 16129 − 128 + 128 + 128 = 16257 (0x00003F81).
- **Stream gaps:** same stimulus as the basic job with `DI_valid` low on alternate cycles → identical writes and addresses; `done` is delayed only.
- **Backpressure and overflow:** `acc_len=1`, `out_total=6`, `wr_ready=0` during 6 consecutive beats of value p=1 → `overflow=1`. After `wr_ready` rises, exactly 4 writes to dst..dst+3, then `done`.
- **Zero length:** `acc_len=0` → `ack` then `done` on the following cycle; `busy=0` and `wr_wen=0` throughout.
- **Reset mid-operation:** assert `rst` for one cycle after 2 of 3 beats → all outputs 0, no write. A new config then runs the basic job correctly.
